// File: rtl/exe_stage_pkg.sv
// Shared bus widths, inter-stage bundles and ALU op indices
// for the execute stage of the 5-stage MIPS pipeline.
package exe_stage_pkg;

   localparam int DS_TO_ES_BUS_WD = 136;
   localparam int ES_TO_MS_BUS_WD = 71;
   localparam int ES_FWD_BUS_WD   = 40;
   localparam int ALU_OP_WD       = 12;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_LUI  = 11;

   typedef struct packed {
      logic [ALU_OP_WD-1:0] alu_op;
      logic                 res_from_mem;
      logic                 src1_is_sa;
      logic                 src1_is_pc;
      logic                 src2_is_imm;
      logic                 src2_is_8;
      logic                 gr_we;
      logic                 mem_we;
      logic [4:0]           dest;
      logic [15:0]          imm;
      logic [31:0]          rs_value;
      logic [31:0]          rt_value;
      logic [31:0]          pc;
   } ds_to_es_t;

   typedef struct packed {
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } es_to_ms_t;

   typedef struct packed {
      logic        valid;
      logic        gr_we;
      logic        res_from_mem;
      logic [4:0]  dest;
      logic [31:0] alu_result;
   } es_fwd_t;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU: one-hot op select, 32-bit modulo arithmetic,
// all-zero op gives zero.
module alu
   import exe_stage_pkg::*;
(
   input  logic [ALU_OP_WD-1:0] alu_op,
   input  logic [31:0]          src1,
   input  logic [31:0]          src2,
   output logic [31:0]          result
);

   logic [4:0] sa;

   assign sa = src1[4:0];

   always_comb begin
      result = 32'b0;
      unique case (1'b1)
         alu_op[ALU_ADD]:  result = src1 + src2;
         alu_op[ALU_SUB]:  result = src1 - src2;
         alu_op[ALU_SLT]:
            result = {31'b0, $signed(src1) < $signed(src2)};
         alu_op[ALU_SLTU]: result = {31'b0, src1 < src2};
         alu_op[ALU_AND]:  result = src1 & src2;
         alu_op[ALU_NOR]:  result = ~(src1 | src2);
         alu_op[ALU_OR]:   result = src1 | src2;
         alu_op[ALU_XOR]:  result = src1 ^ src2;
         alu_op[ALU_SLL]:  result = src2 << sa;
         alu_op[ALU_SRL]:  result = src2 >> sa;
         alu_op[ALU_SRA]:
            result = $unsigned($signed(src2) >>> sa);
         alu_op[ALU_LUI]:  result = {src2[15:0], 16'b0};
         default:          result = 32'b0;
      endcase
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: pipeline register, operand select, ALU and
// data SRAM req/addr_ok request FSM.
module exe_stage
   import exe_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ms_allowin,
   output logic                       es_allowin,
   input  logic                       ds_to_es_valid,
   input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
   output logic                       es_to_ms_valid,
   output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
   output logic                       data_sram_req,
   output logic                       data_sram_wr,
   output logic [31:0]                data_sram_addr,
   output logic [31:0]                data_sram_wdata,
   input  logic                       data_sram_addr_ok
);

   typedef enum logic {
      IDLE = 1'b0,
      SENT = 1'b1
   } req_st_t;

   req_st_t   state;
   req_st_t   state_nx;
   logic      es_valid;
   ds_to_es_t ds_r;
   logic      es_ready_go;
   logic      mem_op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [31:0] alu_result;
   es_to_ms_t ms_b;
   es_fwd_t   fwd_b;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         es_valid <= 1'b0;
      end else if (es_allowin) begin
         es_valid <= ds_to_es_valid;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ds_r <= '0;
      end else if (ds_to_es_valid && es_allowin) begin
         ds_r <= ds_to_es_bus;
      end
   end

   assign mem_op = es_valid
                 && (ds_r.res_from_mem || ds_r.mem_we);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Accepted but stalled requests park in SENT so they
   // are never re-issued while waiting on ms_allowin.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:
            if (mem_op && data_sram_addr_ok && !ms_allowin)
               state_nx = SENT;
         SENT:
            if (ms_allowin)
               state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      data_sram_req = 1'b0;
      es_ready_go   = 1'b1;
      unique case (state)
         IDLE: begin
            data_sram_req = mem_op;
            if (mem_op)
               es_ready_go = data_sram_addr_ok;
         end
         SENT: es_ready_go = 1'b1;
         default: es_ready_go = 1'b1;
      endcase
   end

   assign es_allowin = !es_valid
                     || (es_ready_go && ms_allowin);
   assign es_to_ms_valid = es_valid && es_ready_go;

   assign src1 = ds_r.src1_is_sa ? {27'b0, ds_r.imm[10:6]}
               : ds_r.src1_is_pc ? ds_r.pc
               : ds_r.rs_value;

   assign src2 = ds_r.src2_is_imm ? sext16(ds_r.imm)
               : ds_r.src2_is_8   ? 32'd8
               : ds_r.rt_value;

   alu u_alu (
      .alu_op (ds_r.alu_op),
      .src1   (src1),
      .src2   (src2),
      .result (alu_result)
   );

   assign data_sram_wr    = ds_r.mem_we;
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = ds_r.rt_value;

   always_comb begin
      ms_b.res_from_mem = ds_r.res_from_mem;
      ms_b.gr_we        = ds_r.gr_we;
      ms_b.dest         = ds_r.dest;
      ms_b.alu_result   = alu_result;
      ms_b.pc           = ds_r.pc;
   end

   always_comb begin
      fwd_b.valid        = es_valid;
      fwd_b.gr_we        = ds_r.gr_we;
      fwd_b.res_from_mem = ds_r.res_from_mem;
      fwd_b.dest         = ds_r.dest;
      fwd_b.alu_result   = alu_result;
   end

   assign es_to_ms_bus = ms_b;
   assign es_fwd_bus   = fwd_b;

endmodule
